// File: rtl/cardinal_nic.sv
// One-packet-deep NIC between a CPU register port and a ring router's local port.
// Buffers use big-endian bit numbering in the packet format: packet bit 0 (the VC bit) is the MSB here.
module cardinal_nic #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        nicAddr,
  input  logic [DATA_W-1:0] nicDataIn,
  output logic [DATA_W-1:0] nicDataOut,
  input  logic              nicEn,
  input  logic              nicWrEn,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_polarity
);

  localparam logic [1:0] ADDR_IN_BUF  = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  logic [DATA_W-1:0] r_in_buf;
  logic              r_in_full;
  logic [DATA_W-1:0] r_out_buf;
  logic              r_out_full;

  logic w_cpu_rd;
  logic w_rd_in_buf;
  logic w_wr_out_buf;
  logic w_capture;
  logic w_drain;

  assign w_cpu_rd     = nicEn & ~nicWrEn;
  assign w_rd_in_buf  = w_cpu_rd & (nicAddr == ADDR_IN_BUF) & r_in_full;
  assign w_wr_out_buf = nicEn & nicWrEn & (nicAddr == ADDR_OUT_BUF) & ~r_out_full;
  assign w_capture    = net_si & ~r_in_full;
  assign w_drain      = net_so & net_ro;

  assign net_ri = ~r_in_full;
  assign net_do = r_out_buf;
  // VC bit is packet bit 0, i.e. the MSB of the bus
  assign net_so = r_out_full & (r_out_buf[DATA_W-1] == net_polarity);

  always_comb begin
    nicDataOut = '0;
    if (w_cpu_rd) begin
      case (nicAddr)
        ADDR_IN_BUF:   nicDataOut = r_in_buf;
        ADDR_IN_STAT:  nicDataOut = {{(DATA_W-1){1'b0}}, r_in_full};
        ADDR_OUT_BUF:  nicDataOut = '0;
        ADDR_OUT_STAT: nicDataOut = {{(DATA_W-1){1'b0}}, r_out_full};
        default:       nicDataOut = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_buf  <= '0;
      r_in_full <= 1'b0;
    end else if (w_capture) begin
      r_in_buf  <= net_di;
      r_in_full <= 1'b1;
    end else if (w_rd_in_buf) begin
      r_in_full <= 1'b0;
    end
  end

  // A write can only land while empty, so it never collides with a drain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_buf  <= '0;
      r_out_full <= 1'b0;
    end else if (w_wr_out_buf) begin
      r_out_buf  <= nicDataIn;
      r_out_full <= 1'b1;
    end else if (w_drain) begin
      r_out_full <= 1'b0;
    end
  end

endmodule

// File: doc/cardinal_nic.md
# cardinal_nic

Network interface controller between the processor's 2-bit NIC port and its ring router's local port. Holds one 64-bit packet in each direction: an input channel buffer fills from the router and drains when the CPU reads it. An output channel buffer fills from a CPU write and drains to the router under a ready/valid handshake gated by the router's virtual-channel polarity. The CPU polls two status registers to pace traffic.

## Interface

Parameters:
- DATA_W, 64, packet and CPU data width; packet bit 0 is the VC bit.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- nicAddr  input  2  CPU register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status
- nicDataIn  input  64  CPU write data
- nicDataOut  output  64  CPU read data
- nicEn  input  1  CPU access enable
- nicWrEn  input  1  1 = write, 0 = read; meaningful only when nicEn=1
- net_si  input  1  router offers a packet to the NIC
- net_ri  output  1  NIC can accept a packet (input buffer empty)
- net_di  input  64  packet from router
- net_so  output  1  NIC offers a packet to the router
- net_ro  input  1  router can accept a packet
- net_do  output  64  packet to router
- net_polarity  input  1  router's current VC polarity

## Operation

- State: in_buf[0:63], in_full; out_buf[0:63], out_full.
- Router to NIC:
  - net_ri = ~in_full, driven from the register only.
  - On a posedge with net_si & net_ri: in_buf <= net_di and in_full <= 1.
  - A net_si pulse while in_full=1 is dropped, because the router must not assert net_si when net_ri=0.
- CPU read, nicEn=1 and nicWrEn=0; nicDataOut is combinational:
  - 00 returns in_buf. At the next posedge, in_full <= 0 if it was 1. Reading while empty returns the stale in_buf and leaves state unchanged.
  - 01 returns 63'b0 concatenated with in_full in bit 63.
  - 10 returns 64'b0.
  - 11 returns 63'b0 concatenated with out_full in bit 63.
  - When nicEn=0 or a write is in progress, nicDataOut = 64'b0.
- CPU write, nicEn=1 and nicWrEn=1:
  - 10 with out_full=0: out_buf <= nicDataIn and out_full <= 1 at the posedge.
  - 10 with out_full=1: ignored, and out_buf is not overwritten.
  - 00, 01 and 11: ignored.
- NIC to router:
  - net_do = out_buf.
  - net_so = out_full & (out_buf[0] == net_polarity).
  - On a posedge with net_so & net_ro: out_full <= 0. out_buf holds its value.
- Simultaneous events:
  - CPU write to 10 in the same cycle the router drains out_buf: the write is ignored because out_full is still 1 in that cycle. The CPU re-polls 11.
  - CPU read of 00 in the same cycle net_si arrives cannot occur, because net_ri=0 while in_full=1.
  - Input and output paths are fully independent and may transfer in the same cycle.

## Timing

- Reset values: in_buf = out_buf = 0, in_full = out_full = 0, net_ri = 1, net_so = 0, net_do = 0, nicDataOut = 0.
- Reset asserted mid-transfer clears both buffers immediately; any packet held is lost.
- Router-to-CPU latency: a packet captured at edge N is readable, and status 01 reads 1, in cycle N+1. A read of 00 in cycle N+1 frees the buffer at edge N+2, so net_ri=1 in cycle N+2.
- CPU-to-router latency: a write at edge N gives net_so=1 in cycle N+1 if the polarity matches. Otherwise net_so waits for the polarity to toggle.
- net_so and net_ri depend only on registers and net_polarity. No input-to-output path exists from net_si or net_ro.
- One packet in each direction at most every two cycles. There is no bypass path.

## Test plan

- Reset: hold reset for 3 cycles -> net_ri=1, net_so=0, reads of 01 and 11 return 0.
- Inbound packet:
  - Drive net_si=1 with net_di=64'h0000_1234_0000_ABCD -> net_ri=0 next cycle, and reading 01 gives 64'h1.
  - Reading 00 returns 64'h0000_1234_0000_ABCD -> net_ri=1 one cycle after the read.
- Outbound polarity gating:
  - Write 64'h8000_0000_0000_0055 to 10 with net_polarity=0 -> net_so stays 0.
  - Toggle net_polarity to 1 with net_ro=1 -> net_so=1 and net_do matches the written value; out_full clears and 11 reads 0 the next cycle.
- Full-buffer write: write A to 10 with net_ro=0, then write B -> net_do stays A and 11 reads 1. After the drain, write B -> net_do=B.
- Concurrency: inbound capture, outbound drain and a CPU read of 11 all in the same cycle -> both transfers complete, and the status read returns the pre-edge value 1.
- Reset mid-operation: assert reset with both buffers full -> net_ri=1 and net_so=0 at once, and status reads return 0.
